// File: rtl/exe_stage.sv
// Execute stage of the 16-bit pipeline: ALU, branch/JAL resolution, an iterative
// shift-add multiplier and the EX/MEM register that feeds the memory stage.
module exe_stage #(
   parameter int WIDTH      = 16,
   parameter int MUL_CYCLES = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] next_pc,
   input  logic [WIDTH-1:0] imm,
   input  logic [WIDTH-1:0] rdata1,
   input  logic [WIDTH-1:0] rdata2,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       alu_op,
   input  logic             reg_wen,
   input  logic             mem_wen,
   input  logic             mem_ren,
   input  logic             mem_to_reg,
   input  logic [3:0]       reg_waddr,
   input  logic             branch,
   input  logic             jal,
   output logic [WIDTH-1:0] result_out,
   output logic [WIDTH-1:0] store_data_out,
   output logic             reg_wen_out,
   output logic             mem_wen_out,
   output logic             mem_ren_out,
   output logic             mem_to_reg_out,
   output logic [3:0]       reg_waddr_out,
   output logic             flush,
   output logic [WIDTH-1:0] target_pc,
   output logic             stall
);
   localparam int SH_W  = $clog2(WIDTH);
   localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(MUL_CYCLES - 1);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] count_reg, count_next;
   logic [WIDTH-1:0] a_reg, b_reg, acc_reg;
   logic [WIDTH-1:0] mul_store_reg;
   logic [3:0]       mul_waddr_reg;
   logic             mul_reg_wen_reg, mul_mem_wen_reg, mul_mem_ren_reg, mul_mem_to_reg_reg;
   logic [WIDTH-1:0] alu_result, addend, acc_sum;
   logic             mul_trigger, mul_last, stall_int;

   always_comb begin
      alu_result = '0;
      case (alu_op)
         3'd0:    alu_result = rdata1 + b;
         3'd1:    alu_result = rdata1 - b;
         3'd2:    alu_result = rdata1 & b;
         3'd3:    alu_result = rdata1 | b;
         3'd4:    alu_result = rdata1 ^ b;
         3'd5:    alu_result = rdata1 << b[SH_W-1:0];
         3'd6:    alu_result = rdata1 >> b[SH_W-1:0];
         default: alu_result = '0;
      endcase
   end

   assign mul_trigger = (alu_op == 3'd7) && reg_wen;
   assign mul_last    = (state_reg == BUSY) && (count_reg == LAST);
   // b_reg shifts right each iteration, so bit 0 is always the current multiplier bit
   assign addend      = b_reg[0] ? (a_reg << count_reg) : '0;
   assign acc_sum     = acc_reg + addend;

   always_comb begin
      state_next = state_reg;
      count_next = count_reg;
      stall_int  = 1'b0;
      case (state_reg)
         IDLE: begin
            if (mul_trigger) begin
               stall_int  = 1'b1;
               state_next = BUSY;
               count_next = '0;
            end
         end
         BUSY: begin
            if (mul_last) begin
               state_next = IDLE;
               count_next = '0;
            end else begin
               stall_int  = 1'b1;
               count_next = count_reg + 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Redirect outputs are forced low during reset so the held pipeline sees no spurious flush
   assign stall     = rst && stall_int;
   assign flush     = rst && (state_reg == IDLE) && (jal || (branch && (rdata1 == '0)));
   assign target_pc = rst ? (next_pc + imm) : '0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= IDLE;
         count_reg <= '0;
      end else begin
         state_reg <= state_next;
         count_reg <= count_next;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         a_reg              <= '0;
         b_reg              <= '0;
         acc_reg            <= '0;
         mul_store_reg      <= '0;
         mul_waddr_reg      <= '0;
         mul_reg_wen_reg    <= 1'b0;
         mul_mem_wen_reg    <= 1'b0;
         mul_mem_ren_reg    <= 1'b0;
         mul_mem_to_reg_reg <= 1'b0;
      end else if (state_reg == IDLE && mul_trigger) begin
         a_reg              <= rdata1;
         b_reg              <= b;
         acc_reg            <= '0;
         mul_store_reg      <= rdata2;
         mul_waddr_reg      <= reg_waddr;
         mul_reg_wen_reg    <= reg_wen;
         mul_mem_wen_reg    <= mem_wen;
         mul_mem_ren_reg    <= mem_ren;
         mul_mem_to_reg_reg <= mem_to_reg;
      end else if (state_reg == BUSY) begin
         acc_reg <= acc_sum;
         b_reg   <= b_reg >> 1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         result_out     <= '0;
         store_data_out <= '0;
         reg_wen_out    <= 1'b0;
         mem_wen_out    <= 1'b0;
         mem_ren_out    <= 1'b0;
         mem_to_reg_out <= 1'b0;
         reg_waddr_out  <= '0;
      end else if (mul_last) begin
         result_out     <= acc_sum;
         store_data_out <= mul_store_reg;
         reg_wen_out    <= mul_reg_wen_reg;
         mem_wen_out    <= mul_mem_wen_reg;
         mem_ren_out    <= mul_mem_ren_reg;
         mem_to_reg_out <= mul_mem_to_reg_reg;
         reg_waddr_out  <= mul_waddr_reg;
      end else if (state_reg == BUSY || mul_trigger) begin
         // bubble: control cleared, data fields left as they were
         reg_wen_out    <= 1'b0;
         mem_wen_out    <= 1'b0;
         mem_ren_out    <= 1'b0;
         mem_to_reg_out <= 1'b0;
      end else begin
         result_out     <= jal ? next_pc : alu_result;
         store_data_out <= rdata2;
         reg_wen_out    <= reg_wen;
         mem_wen_out    <= mem_wen;
         mem_ren_out    <= mem_ren;
         mem_to_reg_out <= mem_to_reg;
         reg_waddr_out  <= reg_waddr;
      end
   end
endmodule

// File: tb/tb_exe_stage.sv
// Bench for exe_stage: directed cases plus randomized traffic checked every cycle
// against a behavioural model (plain arithmetic product, countdown to result).
module tb_exe_stage;
   localparam int MUL_CYCLES = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] next_pc, imm, rdata1, rdata2, b;
   logic [2:0]  alu_op;
   logic        reg_wen, mem_wen, mem_ren, mem_to_reg, branch, jal;
   logic [3:0]  reg_waddr;
   logic [15:0] result_out, store_data_out, target_pc;
   logic        reg_wen_out, mem_wen_out, mem_ren_out, mem_to_reg_out, flush, stall;
   logic [3:0]  reg_waddr_out;

   int n_cmp = 0;
   int n_bad = 0;
   logic cmp_en = 1'b0;

   always #5 clk = ~clk;

   exe_stage #(.WIDTH(16), .MUL_CYCLES(MUL_CYCLES)) dut (
      .clk(clk), .rst(rst), .next_pc(next_pc), .imm(imm), .rdata1(rdata1),
      .rdata2(rdata2), .b(b), .alu_op(alu_op), .reg_wen(reg_wen), .mem_wen(mem_wen),
      .mem_ren(mem_ren), .mem_to_reg(mem_to_reg), .reg_waddr(reg_waddr),
      .branch(branch), .jal(jal), .result_out(result_out),
      .store_data_out(store_data_out), .reg_wen_out(reg_wen_out),
      .mem_wen_out(mem_wen_out), .mem_ren_out(mem_ren_out),
      .mem_to_reg_out(mem_to_reg_out), .reg_waddr_out(reg_waddr_out),
      .flush(flush), .target_pc(target_pc), .stall(stall)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [15:0] e_result = '0, e_store = '0, mul_prod = '0;
   logic        e_rw = 0, e_mw = 0, e_mr = 0, e_mtr = 0;
   logic        m_rw = 0, m_mw = 0, m_mr = 0, m_mtr = 0;
   logic [3:0]  e_waddr = '0, m_waddr = '0;
   logic        waddr_known = 1, store_known = 1;
   int          mul_left = 0;   // edges still to go before the product lands

   function automatic logic [15:0] alu_ref(input logic [2:0] op, input logic [15:0] x, input logic [15:0] y);
      case (op)
         3'd0: return x + y;
         3'd1: return x - y;
         3'd2: return x & y;
         3'd3: return x | y;
         3'd4: return x ^ y;
         3'd5: return x << y[3:0];
         3'd6: return x >> y[3:0];
         default: return 16'h0;
      endcase
   endfunction

   function automatic logic is_mul();
      return (alu_op == 3'd7) && reg_wen;
   endfunction

   function automatic logic model_stall();
      if (!rst) return 1'b0;
      if (mul_left > 0) return mul_left > 1;
      return is_mul();
   endfunction

   function automatic logic model_flush();
      return rst && (mul_left == 0) && (jal || (branch && rdata1 == 16'h0));
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         e_result <= '0; e_store <= '0; e_waddr <= '0;
         e_rw <= 0; e_mw <= 0; e_mr <= 0; e_mtr <= 0;
         waddr_known <= 1; store_known <= 1; mul_left <= 0;
      end else if (mul_left > 0) begin
         if (mul_left == 1) begin
            e_result <= mul_prod; e_waddr <= m_waddr;
            e_rw <= m_rw; e_mw <= m_mw; e_mr <= m_mr; e_mtr <= m_mtr;
            waddr_known <= 1; store_known <= 0;
         end else begin
            e_rw <= 0; e_mw <= 0; e_mr <= 0; e_mtr <= 0;
         end
         mul_left <= mul_left - 1;
      end else if (is_mul()) begin
         mul_prod <= rdata1 * b;
         m_rw <= reg_wen; m_mw <= mem_wen; m_mr <= mem_ren; m_mtr <= mem_to_reg;
         m_waddr <= reg_waddr;
         mul_left <= MUL_CYCLES;
         e_rw <= 0; e_mw <= 0; e_mr <= 0; e_mtr <= 0;
         waddr_known <= 0; store_known <= 0;
      end else begin
         e_result <= jal ? next_pc : alu_ref(alu_op, rdata1, b);
         e_store <= rdata2; e_waddr <= reg_waddr;
         e_rw <= reg_wen; e_mw <= mem_wen; e_mr <= mem_ren; e_mtr <= mem_to_reg;
         waddr_known <= 1; store_known <= 1;
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("stall", stall, model_stall());
         chk("flush", flush, model_flush());
         chk("target_pc", target_pc, rst ? 16'(next_pc + imm) : 16'h0);
         chk("result_out", result_out, e_result);
         chk("ctl_out", {reg_wen_out, mem_wen_out, mem_ren_out, mem_to_reg_out},
             {e_rw, e_mw, e_mr, e_mtr});
         if (waddr_known) chk("reg_waddr_out", reg_waddr_out, e_waddr);
         if (store_known) chk("store_data_out", store_data_out, e_store);
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic drive(input logic [2:0] op, input logic [15:0] a, input logic [15:0] bb,
                        input logic wen, input logic [3:0] wa);
      alu_op = op; rdata1 = a; b = bb; reg_wen = wen; reg_waddr = wa;
      mem_wen = 0; mem_ren = 0; mem_to_reg = 0; branch = 0; jal = 0;
      next_pc = 16'h0; imm = 16'h0; rdata2 = 16'h0;
   endtask

   task automatic bubble();
      drive(3'd0, 16'h0, 16'h0, 1'b0, 4'h0);
   endtask

   task automatic rand_instr();
      alu_op = 3'($urandom_range(0, 7));
      rdata1 = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      rdata2 = 16'($urandom); b = 16'($urandom);
      imm = 16'($urandom); next_pc = 16'($urandom);
      reg_wen = 1'($urandom); mem_wen = 1'($urandom);
      mem_ren = 1'($urandom); mem_to_reg = 1'($urandom);
      reg_waddr = 4'($urandom);
      branch = ($urandom_range(0, 7) == 0);
      jal = ($urandom_range(0, 15) == 0);
   endtask

   task automatic do_mul(input logic [15:0] a, input logic [15:0] bb, input logic [15:0] exp);
      int ns = 0;
      bit done = 0;
      drive(3'd7, a, bb, 1'b1, 4'd9);
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge clk);
         if (stall) begin
            ns++;
            chk("mul_bubble_reg_wen", reg_wen_out, 1'b0);
         end else begin
            done = 1;
         end
      end
      chk("mul_stall_cycles", ns, 16);
      step();
      bubble();
      @(negedge clk);
      chk("mul_result", result_out, exp);
      chk("mul_reg_wen", reg_wen_out, 1'b1);
      chk("mul_waddr", reg_waddr_out, 4'd9);
      chk("model_mul", e_result, exp);
   endtask

   logic [2:0]  sw_op  [5] = '{3'd1, 3'd5, 3'd6, 3'd4, 3'd0};
   logic [15:0] sw_b   [5] = '{16'h0003, 16'h0003, 16'h0003, 16'h0003, 16'hFFFF};
   logic [15:0] sw_exp [5] = '{16'h7FFE, 16'h0008, 16'h1000, 16'h8002, 16'h8000};

   initial begin
      bubble();
      #1 rst = 1'b0;
      cmp_en = 1'b1;
      step(); step();
      rst = 1'b1;
      for (int i = 0; i < 200; i++) begin
         logic h, f;
         h = model_stall(); f = model_flush();
         step();
         if (!h) begin
            if (f) bubble(); else rand_instr();
         end
      end

      // reset held mid-run with arbitrary inputs
      rst = 1'b0;
      rand_instr();
      alu_op = 3'd7; reg_wen = 1'b1; jal = 1'b1;
      @(negedge clk);
      chk("rst_result", result_out, 16'h0);
      chk("rst_stall", stall, 1'b0);
      chk("rst_flush", flush, 1'b0);
      chk("rst_reg_wen", reg_wen_out, 1'b0);
      step();
      rst = 1'b1;
      drive(3'd0, 16'd3, 16'd4, 1'b1, 4'd5);
      step();
      bubble();
      @(negedge clk);
      chk("add_result", result_out, 16'd7);
      chk("add_waddr", reg_waddr_out, 4'd5);
      chk("add_reg_wen", reg_wen_out, 1'b1);

      for (int i = 0; i < 5; i++) begin
         step();
         drive(sw_op[i], 16'h8001, sw_b[i], 1'b1, 4'd2);
         step();
         bubble();
         @(negedge clk);
         chk($sformatf("alu_op%0d", sw_op[i]), result_out, sw_exp[i]);
         chk($sformatf("model_alu_op%0d", sw_op[i]), e_result, sw_exp[i]);
      end

      step();
      bubble(); branch = 1; rdata1 = 16'h0; next_pc = 16'h0010; imm = 16'hFFFC;
      #1;
      chk("beqz_taken_flush", flush, 1'b1);
      chk("beqz_target", target_pc, 16'h000C);
      rdata1 = 16'h0001;
      #1;
      chk("beqz_not_taken_flush", flush, 1'b0);

      step();
      bubble(); jal = 1; branch = 1; rdata1 = 16'd5; next_pc = 16'h0020; imm = 16'h0004;
      #1;
      chk("jal_flush", flush, 1'b1);
      chk("jal_target", target_pc, 16'h0024);
      step();
      bubble();
      @(negedge clk);
      chk("jal_link", result_out, 16'h0020);

      step();
      do_mul(16'd300, 16'd250, 16'h24F8);
      step();
      do_mul(16'hFFFF, 16'hFFFF, 16'h0001);

      // reset while the multiplier is at iteration 7
      step();
      drive(3'd7, 16'd300, 16'd250, 1'b1, 4'd9);
      for (int i = 0; i < 8; i++) step();
      rst = 1'b0;
      #1;
      chk("midmul_rst_stall", stall, 1'b0);
      chk("midmul_rst_result", result_out, 16'h0);
      step();
      rst = 1'b1;
      drive(3'd0, 16'd3, 16'd4, 1'b1, 4'd5);
      #1;
      chk("post_rst_add_stall", stall, 1'b0);
      step();
      bubble();
      @(negedge clk);
      chk("post_rst_add_result", result_out, 16'd7);

      // randomized traffic with occasional resets
      for (int i = 0; i < 4000; i++) begin
         logic h, f;
         if ($urandom_range(0, 299) == 0) begin
            rst = 1'b0;
            rand_instr();
            step();
            rst = 1'b1;
         end
         h = model_stall(); f = model_flush();
         step();
         if (!h) begin
            if (f) bubble(); else rand_instr();
         end
      end

      @(negedge clk);
      cmp_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
